fetch_stage: RTL

- Instruction-fetch stage plus F/D pipeline latch, directly upstream of the instruction decoder.
- Holds the program counter and drives the word address to instruction memory.
- Captures the returned 32-bit instruction with its PC into the F/D latch; the decoder slices the latched instruction into opcode/rd/rs/rt/shamt/aluop/imm/target fields.
- Handles stall (hold), redirect from branch/jump resolution (load new PC, squash F/D), and bubble insertion.

---
 rtl/proc_pkg.sv | 63 ++++++
 rtl/fetch_stage_if.sv | 43 ++++
 rtl/fetch_stage_fd_latch.sv | 40 ++++
 rtl/fetch_stage.sv | 68 ++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction/PC widths, the bubble encoding,
// opcode constants and instruction field positions used by fetch and decode.
package proc_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  // Bubble instruction: opcode 0, aluop 0, rd = $0 (add $0,$0,$0).
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Opcode field constants.
  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  // Instruction field bit positions.
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 27;
  localparam int RD_HI     = 26;
  localparam int RD_LO     = 22;
  localparam int RS_HI     = 21;
  localparam int RS_LO     = 17;
  localparam int RT_HI     = 16;
  localparam int RT_LO     = 12;
  localparam int SHAMT_HI  = 11;
  localparam int SHAMT_LO  = 7;
  localparam int ALUOP_HI  = 6;
  localparam int ALUOP_LO  = 2;
  localparam int IMM_HI    = 16;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 26;
  localparam int TARGET_LO = 0;

  // Contents of the F/D pipeline latch.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus1;
    logic               valid;
  } fd_t;

  // F/D contents representing an empty slot.
  function automatic fd_t fd_bubble();
    fd_t b;
    b.instr    = NOP_INSTR;
    b.pc       = 32'd0;
    b.pc_plus1 = 32'd0;
    b.valid    = 1'b0;
    return b;
  endfunction

  // Opcode slice of an instruction word.
  function automatic logic [4:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and the
// F/D latch outputs toward the decoder.
interface fetch_stage_if #(
  parameter int ADDR_W = 12
) ();

  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       q_imem;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [31:0]       fd_instr;
  logic [31:0]       fd_pc;
  logic [31:0]       fd_pc_plus1;
  logic              fd_valid;

  // Fetch stage side.
  modport master (
    output imem_addr,
    input  q_imem,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output fd_instr,
    output fd_pc,
    output fd_pc_plus1,
    output fd_valid
  );

  // Environment side: memory, hazard unit, branch resolution, decoder.
  modport slave (
    input  imem_addr,
    output q_imem,
    output stall,
    output redirect,
    output redirect_pc,
    input  fd_instr,
    input  fd_pc,
    input  fd_pc_plus1,
    input  fd_valid
  );

endinterface

// File: rtl/fetch_stage_fd_latch.sv
// F/D pipeline register: hold when not enabled, synchronous clear to bubble,
// clear wins over enable, reset wins over everything.
module fd_latch
  import proc_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  fd_t  d,
  output fd_t  q
);

  fd_t fd_d;
  fd_t fd_q;

  // Next latch contents: clear to bubble, load, or hold.
  always_comb begin
    fd_d = fd_q;
    if (clr) begin
      fd_d = fd_bubble();
    end else if (en) begin
      fd_d = d;
    end else begin
      fd_d = fd_q;
    end
  end

  // Latch register with synchronous reset to bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      fd_q <= fd_bubble();
    end else begin
      fd_q <= fd_d;
    end
  end

  assign q = fd_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall/sequential next-PC
// selection, feeding the F/D latch that presents instructions to the decoder.
module fetch_stage
  import proc_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic          clock,
  input logic          reset,
  fetch_stage_if.master bus
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_plus1_s;
  fd_t             fd_in;
  fd_t             fd_out;

  assign pc_plus1_s = pc_q + 32'd1;

  // Next PC: redirect beats stall beats sequential increment (wraps modulo 2^32).
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect) begin
      pc_d = bus.redirect_pc;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus1_s;
    end
  end

  // PC register.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Candidate F/D contents: the word fetched at the current PC.
  always_comb begin
    fd_in          = fd_bubble();
    fd_in.instr    = bus.q_imem;
    fd_in.pc       = pc_q;
    fd_in.pc_plus1 = pc_plus1_s;
    fd_in.valid    = 1'b1;
  end

  // A redirect squashes the in-flight fetch; a stall freezes the latch.
  fd_latch u_fd_latch (
    .clock (clock),
    .reset (reset),
    .clr   (bus.redirect),
    .en    (~bus.stall),
    .d     (fd_in),
    .q     (fd_out)
  );

  assign bus.imem_addr   = pc_q[ADDR_W-1:0];
  assign bus.fd_instr    = fd_out.instr;
  assign bus.fd_pc       = fd_out.pc;
  assign bus.fd_pc_plus1 = fd_out.pc_plus1;
  assign bus.fd_valid    = fd_out.valid;

endmodule
